// File: rtl/ysyx_23060203_axi_rd_arb.sv
// ysyx_23060203_axi_rd_arb
// Round-robin 2:1 arbiter for the AXI4 read channels of the IFU (master 0) and
// LSU (master 1) onto a single read slave. Only one read is in flight at a time;
// the grant is taken in IDLE and held until the last data beat is accepted.
module ysyx_23060203_axi_rd_arb #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              clock,
   input  logic              reset,
   // master 0 (IFU)
   input  logic              m0_arvalid,
   output logic              m0_arready,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [ID_W-1:0]   m0_arid,
   input  logic [7:0]        m0_arlen,
   input  logic [2:0]        m0_arsize,
   input  logic [1:0]        m0_arburst,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   output logic [ID_W-1:0]   m0_rid,
   // master 1 (LSU)
   input  logic              m1_arvalid,
   output logic              m1_arready,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [ID_W-1:0]   m1_arid,
   input  logic [7:0]        m1_arlen,
   input  logic [2:0]        m1_arsize,
   input  logic [1:0]        m1_arburst,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   output logic [ID_W-1:0]   m1_rid,
   // shared slave
   output logic              s_arvalid,
   input  logic              s_arready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [ID_W-1:0]   s_arid,
   output logic [7:0]        s_arlen,
   output logic [2:0]        s_arsize,
   output logic [1:0]        s_arburst,
   input  logic              s_rvalid,
   output logic              s_rready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   input  logic [ID_W-1:0]   s_rid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state_reg, state_next;
   logic   sel_reg,   sel_next;    // currently granted master
   logic   last_reg,  last_next;   // master whose address was last accepted

   // State, grant and round-robin history registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= IDLE;
         sel_reg   <= 1'b0;
         last_reg  <= 1'b1;        // so master 0 wins the first tie
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         last_reg  <= last_next;
      end
   end

   // Next-state logic: grant in IDLE, wait for AR handshake, then for the last beat
   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (m0_arvalid || m1_arvalid) begin
               state_next = ADDR;
               // on a tie, serve whoever did not get the previous grant
               sel_next   = (m0_arvalid && m1_arvalid) ? ~last_reg : m1_arvalid;
            end
         end
         ADDR: begin
            if (s_arvalid && s_arready) begin
               state_next = DATA;
               last_next  = sel_reg;
            end
         end
         DATA: begin
            if (s_rvalid && s_rready && s_rlast) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Channel steering: only the granted master sees the slave, everything else reads 0
   always_comb begin
      s_arvalid  = 1'b0;
      s_araddr   = '0;
      s_arid     = '0;
      s_arlen    = '0;
      s_arsize   = '0;
      s_arburst  = '0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m0_rdata   = '0;
      m0_rresp   = '0;
      m0_rlast   = 1'b0;
      m0_rid     = '0;
      m1_rvalid  = 1'b0;
      m1_rdata   = '0;
      m1_rresp   = '0;
      m1_rlast   = 1'b0;
      m1_rid     = '0;
      case (state_reg)
         ADDR: begin
            if (!sel_reg) begin
               s_arvalid  = m0_arvalid;
               s_araddr   = m0_araddr;
               s_arid     = m0_arid;
               s_arlen    = m0_arlen;
               s_arsize   = m0_arsize;
               s_arburst  = m0_arburst;
               m0_arready = s_arready;
            end else begin
               s_arvalid  = m1_arvalid;
               s_araddr   = m1_araddr;
               s_arid     = m1_arid;
               s_arlen    = m1_arlen;
               s_arsize   = m1_arsize;
               s_arburst  = m1_arburst;
               m1_arready = s_arready;
            end
         end
         DATA: begin
            // slave rvalid is only honoured here, so an always-valid CLINT never leaks
            if (!sel_reg) begin
               m0_rvalid = s_rvalid;
               m0_rdata  = s_rdata;
               m0_rresp  = s_rresp;
               m0_rlast  = s_rlast;
               m0_rid    = s_rid;
               s_rready  = m0_rready;
            end else begin
               m1_rvalid = s_rvalid;
               m1_rdata  = s_rdata;
               m1_rresp  = s_rresp;
               m1_rlast  = s_rlast;
               m1_rid    = s_rid;
               s_rready  = m1_rready;
            end
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_arb.sv
// Directed bench for ysyx_23060203_axi_rd_arb with a behavioural read slave
// (memory + CLINT mtime at 0x0200_BFF8) and a scoreboard of expected beats.
module tb_ysyx_23060203_axi_rd_arb;

   localparam logic [31:0] CLINT_ADDR = 32'h0200_BFF8;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
   logic [31:0] m0_araddr, m0_rdata;
   logic [3:0]  m0_arid, m0_rid;
   logic [7:0]  m0_arlen;
   logic [2:0]  m0_arsize;
   logic [1:0]  m0_arburst, m0_rresp;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
   logic [31:0] m1_araddr, m1_rdata;
   logic [3:0]  m1_arid, m1_rid;
   logic [7:0]  m1_arlen;
   logic [2:0]  m1_arsize;
   logic [1:0]  m1_arburst, m1_rresp;
   logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
   logic [31:0] s_araddr, s_rdata;
   logic [3:0]  s_arid, s_rid;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst, s_rresp;

   int passed = 0;
   int total  = 0;
   int failed = 0;

   typedef struct packed {
      logic        mst;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  beat;
      logic        last;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        clint;
   } exp_t;

   exp_t sb[$];

   always #5 clock = ~clock;

   ysyx_23060203_axi_rd_arb #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
      .clock(clock), .reset(reset),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
      .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
      .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
      .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
      .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid)
   );

   // Memory contents seen by the slave: every beat distinguishable, AR attributes folded in
   function automatic logic [31:0] beat_data(input logic [31:0] addr, input logic [7:0] beat,
                                             input logic [2:0] size, input logic [1:0] burst);
      return addr ^ (32'(beat) * 32'h0101_0101) ^ {27'h0, size, burst};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural slave ----------------
   logic        force_rvalid;
   logic        sl_busy;
   logic [31:0] sl_addr, uptime, clint_val;
   logic [3:0]  sl_id;
   logic [7:0]  sl_len, sl_beat;
   logic [2:0]  sl_size;
   logic [1:0]  sl_burst;

   assign s_arready = !sl_busy;

   // Slave R outputs: real data while busy, otherwise CLINT-style garbage if forced valid
   always_comb begin
      s_rvalid = force_rvalid;
      s_rdata  = 32'hDEAD_BEEF;
      s_rresp  = 2'b10;
      s_rlast  = 1'b1;
      s_rid    = 4'hF;
      if (sl_busy) begin
         s_rvalid = 1'b1;
         s_rdata  = (sl_addr == CLINT_ADDR) ? clint_val
                                            : beat_data(sl_addr, sl_beat, sl_size, sl_burst);
         s_rresp  = {1'b0, sl_id[0]};
         s_rlast  = (sl_beat == sl_len);
         s_rid    = sl_id;
      end
   end

   // Slave state: accept one address, then stream arlen+1 beats
   always_ff @(posedge clock) begin
      if (reset) begin
         sl_busy   <= 1'b0;
         uptime    <= 32'd100;
         sl_addr   <= '0;
         sl_id     <= '0;
         sl_len    <= '0;
         sl_beat   <= '0;
         sl_size   <= '0;
         sl_burst  <= '0;
         clint_val <= '0;
      end else begin
         uptime <= uptime + 32'd1;
         if (s_arvalid && s_arready) begin
            sl_busy  <= 1'b1;
            sl_addr  <= s_araddr;
            sl_id    <= s_arid;
            sl_len   <= s_arlen;
            sl_size  <= s_arsize;
            sl_burst <= s_arburst;
            sl_beat  <= '0;
            if (s_araddr == CLINT_ADDR) clint_val <= uptime;
         end else if (sl_busy && s_rready) begin
            if (sl_beat == sl_len) sl_busy <= 1'b0;
            else                   sl_beat <= sl_beat + 8'd1;
         end
      end
   end

   // ---------------- response monitor ----------------
   task automatic check_beat(input logic m, input logic [3:0] rid, input logic [31:0] rdata,
                             input logic [1:0] rresp, input logic rlast);
      exp_t e;
      logic [31:0] exp_data;
      if (sb.size() > 0) begin
         e = sb.pop_front();
      end else begin
         e = '0;
         e.mst = ~m;
      end
      exp_data = e.clint ? clint_val : beat_data(e.addr, e.beat, e.size, e.burst);
      $display("beat: m%0d rid=%0h rdata=%08h rlast=%0b (expect m%0d id=%0h beat=%0d)",
               m, rid, rdata, rlast, e.mst, e.id, e.beat);
      check("r_master", m, e.mst);
      check("r_id", rid, e.id);
      check("r_last", rlast, e.last);
      check("r_resp", rresp, {1'b0, e.id[0]});
      check("r_data", rdata, exp_data);
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         check("no_dual_rvalid", m0_rvalid & m1_rvalid, 1'b0);
         if (sb.size() == 0) check("no_rvalid_leak", {m0_rvalid, m1_rvalid}, 2'b00);
         if (m0_rvalid && m0_rready) check_beat(1'b0, m0_rid, m0_rdata, m0_rresp, m0_rlast);
         if (m1_rvalid && m1_rready) check_beat(1'b1, m1_rid, m1_rdata, m1_rresp, m1_rlast);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      logic h0, h1;
      @(negedge clock);
      h0 = m0_arvalid && m0_arready;
      h1 = m1_arvalid && m1_arready;
      @(posedge clock);
      #1;
      if (h0) m0_arvalid = 1'b0;
      if (h1) m1_arvalid = 1'b0;
   endtask

   task automatic issue(input logic mst, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      exp_t e;
      for (int b = 0; b <= int'(len); b++) begin
         e.mst   = mst;
         e.id    = id;
         e.addr  = addr;
         e.beat  = 8'(b);
         e.last  = (b == int'(len));
         e.size  = size;
         e.burst = burst;
         e.clint = (addr == CLINT_ADDR);
         sb.push_back(e);
      end
      if (!mst) begin
         m0_arvalid = 1'b1; m0_araddr = addr; m0_arid = id;
         m0_arlen = len; m0_arsize = size; m0_arburst = burst;
      end else begin
         m1_arvalid = 1'b1; m1_araddr = addr; m1_arid = id;
         m1_arlen = len; m1_arsize = size; m1_arburst = burst;
      end
      $display("issue: m%0d id=%0h addr=%08h len=%0d", mst, id, addr, len);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while ((sb.size() != 0 || m0_arvalid || m1_arvalid) && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_completes"}, n < budget, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      reset = 1'b1;
      force_rvalid = 1'b1;   // CLINT-like slave: rvalid high from reset onwards
      m0_arvalid = 0; m0_araddr = 0; m0_arid = 0; m0_arlen = 0; m0_arsize = 0; m0_arburst = 0;
      m1_arvalid = 0; m1_araddr = 0; m1_arid = 0; m1_arlen = 0; m1_arsize = 0; m1_arburst = 0;
      m0_rready = 1'b1;
      m1_rready = 1'b1;
      tick();
      tick();
      check("rst_arready", {m0_arready, m1_arready}, 2'b00);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      check("rst_s_arvalid", s_arvalid, 1'b0);
      check("rst_s_rready", s_rready, 1'b0);
      reset = 1'b0;

      // idle with slave rvalid stuck high: nothing may reach a master
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_leak", {m0_rvalid, m1_rvalid, s_rready}, 3'b000);
      end

      // eight ties: master 0 first every time (alternation), then master 1
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, 4'(i),     32'h8000_0000 + 32'(i * 64), 8'(i % 2), 3'd2, 2'b01);
         issue(1'b1, 4'(i + 8), 32'h8000_1000 + 32'(i * 64), 8'(i % 3), 3'd1, 2'b01);
         wait_done("tie", 60);
      end

      // CLINT mtime read by master 0 alone
      issue(1'b0, 4'h5, CLINT_ADDR, 8'd0, 3'd2, 2'b01);
      wait_done("clint", 40);
      check("clint_uptime_nonzero", clint_val != 32'd0, 1'b1);

      // master 1 4-beat burst, master 0 arrives mid-burst and must wait
      issue(1'b1, 4'hA, 32'h8000_2000, 8'd3, 3'd2, 2'b01);
      n = 0;
      while (m1_arvalid && n < 20) begin tick(); n++; end
      check("burst_ar_accepted", m1_arvalid, 1'b0);
      issue(1'b0, 4'h3, 32'h8000_3000, 8'd0, 3'd2, 2'b01);
      n = 0;
      while (sb.size() > 1 && n < 20) begin
         check("burst_m0_arready_low", m0_arready, 1'b0);
         tick();
         n++;
      end
      wait_done("burst", 40);

      // master 0 stalls rready for 5 cycles in DATA
      m0_rready = 1'b0;
      issue(1'b0, 4'h7, 32'h8000_4000, 8'd0, 3'd2, 2'b01);
      n = 0;
      while (!m0_rvalid && n < 20) begin tick(); n++; end
      for (int i = 0; i < 5; i++) begin
         check("stall_s_rready", s_rready, 1'b0);
         check("stall_rvalid", m0_rvalid, 1'b1);
         check("stall_rdata", m0_rdata, beat_data(32'h8000_4000, 8'd0, 3'd2, 2'b01));
         tick();
      end
      m0_rready = 1'b1;
      wait_done("stall", 40);

      // reset in the middle of a burst data phase
      issue(1'b0, 4'h6, 32'h8000_5000, 8'd3, 3'd2, 2'b01);
      n = 0;
      while (!m0_rvalid && n < 20) begin tick(); n++; end
      check("pre_reset_in_data", m0_rvalid, 1'b1);
      reset = 1'b1;
      sb.delete();
      tick();
      check("mid_rst_arready", {m0_arready, m1_arready}, 2'b00);
      check("mid_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      check("mid_rst_s_ar", {s_arvalid, s_araddr}, 33'd0);
      check("mid_rst_s_rready", s_rready, 1'b0);
      check("mid_rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
      reset = 1'b0;
      tick();
      issue(1'b1, 4'h9, 32'h8000_6000, 8'd1, 3'd1, 2'b01);
      wait_done("post_reset", 40);
      check("sb_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
